// File: rtl/background_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : background_ram_writer
//  Description : Streams a background image into the background RAM.
//                Writes happen only while the video timing is in vertical
//                blanking. An interrupted load resumes where it stopped once
//                blanking returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module background_ram_writer #(
    parameter int BG_W        = 160,
    parameter int BG_H        = 120,
    parameter int DATA_W      = 8,
    parameter int VBLANK_LINE = 480,
    parameter int CORDW       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CORDW-1:0]  line,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [15:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    // Number of pixels in one image, and the address of the final pixel.
    // The image must fit the 16-bit address space, so the counter cannot
    // wrap before the final handshake.
    localparam int               c_total     = BG_W * BG_H;
    localparam logic [15:0]      c_last_addr = 16'(c_total - 1);
    localparam logic [CORDW-1:0] c_vblank    = CORDW'(VBLANK_LINE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_WRITE = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t            r_state;
    logic [15:0]       r_addr_cnt;
    logic [15:0]       r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;

    logic              w_vblank;
    logic              w_ready;
    logic              w_handshake;
    logic              w_last;

    // Decode blanking, the stream handshake and the final-pixel condition.
    always_comb begin
        w_vblank    = (line >= c_vblank);
        w_ready     = (r_state == ST_WRITE) && w_vblank;
        w_handshake = w_ready && s_valid;
        w_last      = (r_addr_cnt == c_last_addr);
    end

    // Load sequencer: state, address counter and registered RAM write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr_cnt <= 16'd0;
            r_wr_addr  <= 16'd0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // The write strobe is a one-cycle echo of the handshake.
            r_wr_en <= w_handshake;
            r_done  <= 1'b0;

            if (w_handshake) begin
                r_wr_addr  <= r_addr_cnt;
                r_wr_data  <= s_data;
                r_addr_cnt <= r_addr_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    // A new load always begins at address 0.
                    if (start) begin
                        r_state    <= ST_ARM;
                        r_addr_cnt <= 16'd0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (w_vblank) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // done lines up with the final write strobe.
                    if (w_handshake && w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (!w_vblank) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    // Counter is left untouched so the load resumes in place.
                    if (w_vblank) begin
                        r_state <= ST_WRITE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Drive the ports from the registered state.
    always_comb begin
        s_ready = w_ready;
        wr_addr = r_wr_addr;
        wr_data = r_wr_data;
        wr_en   = r_wr_en;
        busy    = r_busy;
        done    = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_background_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_background_ram_writer
//  Description : Self-checking bench for background_ram_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_background_ram_writer;

    localparam int BG_W        = 160;
    localparam int BG_H        = 120;
    localparam int DATA_W      = 8;
    localparam int VBLANK_LINE = 480;
    localparam int CORDW       = 10;
    localparam int TOTAL       = BG_W * BG_H;

    logic              clk = 1'b0;
    logic              rst;
    logic [CORDW-1:0]  line;
    logic              start;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [15:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;

    background_ram_writer #(
        .BG_W        (BG_W),
        .BG_H        (BG_H),
        .DATA_W      (DATA_W),
        .VBLANK_LINE (VBLANK_LINE),
        .CORDW       (CORDW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .line    (line),
        .start   (start),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a load is "active" from the edge that takes start
    // until the edge of its final handshake. The block accepts a pixel when
    // the load is active and blanking has held for this cycle and the
    // previous cycle of the same load. Pixels are numbered 0..TOTAL-1.
    // ------------------------------------------------------------------
    logic              m_loading;
    logic              m_prev_ok;
    int                m_cnt;
    logic              m_vb;
    logic              m_ready;
    logic              m_hs;
    logic              e_wr_en;
    logic              e_done;
    logic [15:0]       e_addr;
    logic [DATA_W-1:0] e_data;

    always_comb begin
        m_vb    = (int'(line) >= VBLANK_LINE);
        m_ready = m_loading && m_prev_ok && m_vb;
        m_hs    = m_ready && s_valid;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading <= 1'b0;
            m_prev_ok <= 1'b0;
            m_cnt     <= 0;
            e_wr_en   <= 1'b0;
            e_done    <= 1'b0;
            e_addr    <= 16'd0;
            e_data    <= '0;
        end else begin
            e_wr_en   <= m_hs;
            e_done    <= 1'b0;
            m_prev_ok <= m_loading && m_vb;
            if (m_hs) begin
                e_addr <= 16'(m_cnt);
                e_data <= s_data;
                m_cnt  <= m_cnt + 1;
                if (m_cnt == TOTAL - 1) begin
                    m_loading <= 1'b0;
                    e_done    <= 1'b1;
                end
            end else if (!m_loading && start) begin
                m_loading <= 1'b1;
                m_cnt     <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("s_ready", 32'(s_ready), 32'(m_ready));
        chk("busy",    32'(busy),    32'(m_loading));
        chk("wr_en",   32'(wr_en),   32'(e_wr_en));
        chk("done",    32'(done),    32'(e_done));
        if (e_wr_en) begin
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Keep s_valid high with fresh data until done; returns writes observed.
    task automatic stream_to_done(input int budget, output int nwr);
        bit seen;
        nwr  = 0;
        seen = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            s_data = DATA_W'($urandom);
            tick();
            if (wr_en) nwr++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("stream_done_timeout", 32'(done), 32'd1);
    endtask

    logic [6:0] pat;
    int n;
    int k;
    bit found;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        line    = '0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en",   32'(wr_en),   32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        tick();

        // Blanking wait: start during active video with data offered.
        line = 10'd100; s_valid = 1'b1; s_data = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", 32'(busy), 32'd1);
        repeat (5) begin
            tick();
            chk("wait_s_ready", 32'(s_ready), 32'd0);
            chk("wait_wr_en",   32'(wr_en),   32'd0);
        end
        line = 10'd480;
        #1;
        chk("arm_vblank_s_ready", 32'(s_ready), 32'd0);
        tick();
        chk("write_s_ready", 32'(s_ready), 32'd1);
        for (int j = 0; j < 3; j++) begin
            s_data = 8'h20 + DATA_W'(j);
            tick();
            chk("first_wr_en",   32'(wr_en),   32'd1);
            chk("first_wr_addr", 32'(wr_addr), 32'(j));
            chk("first_wr_data", 32'(wr_data), 32'h20 + 32'(j));
        end

        // Full load: the rest of the image in one continuous burst.
        stream_to_done(TOTAL + 100, n);
        chk("full_count",      32'(n + 3),  32'(TOTAL));
        chk("full_last_addr",  32'(wr_addr), 32'(TOTAL - 1));
        chk("full_done",       32'(done),    32'd1);
        chk("full_busy_clear", 32'(busy),    32'd0);

        // Start in the done cycle is taken; then backpressure pattern.
        start = 1'b1; s_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        tick();
        pat = 7'b1011001;   // applied LSB first: 1,0,0,1,1,0,1
        n = 0;
        for (int j = 0; j < 7; j++) begin
            s_valid = pat[j];
            s_data  = 8'h40 + DATA_W'(j);
            tick();
            chk("bp_wr_en", 32'(wr_en), 32'(pat[j]));
            if (pat[j]) begin
                chk("bp_wr_addr", 32'(wr_addr), 32'(n));
                chk("bp_wr_data", 32'(wr_data), 32'h40 + 32'(j));
                n++;
            end
        end
        s_valid = 1'b0;
        tick();
        chk("bp_idle_wr_en", 32'(wr_en), 32'd0);

        // Pause/resume after 5000 writes.
        s_valid = 1'b1;
        k = 4;
        for (int i = 0; i < 6000 && k < 5000; i++) begin
            s_data = DATA_W'($urandom);
            tick();
            if (wr_en) k++;
        end
        chk("pre_pause_addr", 32'(wr_addr), 32'd4999);
        line = 10'd0;
        #1;
        chk("pause_s_ready_now", 32'(s_ready), 32'd0);
        repeat (3) begin
            tick();
            chk("pause_wr_en",   32'(wr_en),   32'd0);
            chk("pause_s_ready", 32'(s_ready), 32'd0);
        end
        line = 10'd480;
        #1;
        chk("paused_vblank_s_ready", 32'(s_ready), 32'd0);
        tick();
        chk("resume_s_ready", 32'(s_ready), 32'd1);
        s_data = 8'h77;
        tick();
        chk("resume_wr_addr", 32'(wr_addr), 32'd5000);
        chk("resume_wr_data", 32'(wr_data), 32'h77);
        stream_to_done(TOTAL, n);
        chk("pause_total", 32'(n + 5001), 32'(TOTAL));

        // Start pulse while writing is ignored.
        s_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; s_valid = 1'b1;
        tick();
        k = 0; found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            s_data = DATA_W'($urandom);
            tick();
            if (wr_en) k++;
            if (wr_en && wr_addr == 16'd300) begin
                found = 1'b1;
                break;
            end
        end
        chk("swb_reached_300", 32'(found), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("swb_next_addr", 32'(wr_addr), 32'd301);
        k++;
        stream_to_done(TOTAL, n);
        chk("swb_total", 32'(k + n), 32'(TOTAL));
        s_valid = 1'b0;
        repeat (3) begin
            tick();
            chk("swb_single_done", 32'(done), 32'd0);
        end

        // Asynchronous reset in the middle of a load.
        start = 1'b1; s_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_wr_en",   32'(wr_en),   32'd0);
        chk("arst_wr_addr", 32'(wr_addr), 32'd0);
        chk("arst_wr_data", 32'(wr_data), 32'd0);
        chk("arst_busy",    32'(busy),    32'd0);
        chk("arst_done",    32'(done),    32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd0);
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        s_data = 8'h5A;
        tick();
        chk("post_rst_wr_en",   32'(wr_en),   32'd1);
        chk("post_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("post_rst_wr_data", 32'(wr_data), 32'h5A);
        s_data = 8'h5B;
        tick();
        chk("post_rst_wr_addr1", 32'(wr_addr), 32'd1);
        s_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
